ddr3_axi_tester: RTL and testbench

Parametrised DDR3 AXI traffic generator and checker for the Pango DDR3 IP user AXI port. It replaces the fixed write/read demo controller with selectable data patterns, configurable burst length and address window, continuous loop mode, per-beat read-back checking, error statistics and a handshake watchdog. It sits between the IP's AXI port and board-level status LEDs or debug capture, clocked by the IP's core_clk.

---
 rtl/ddr3_axi_tester_pkg.sv | 31 +++
 rtl/ddr3_pattern_gen.sv | 51 +++++
 rtl/ddr3_axi_tester.sv | 267 ++++++++++++++++++++++++++
 tb/tb_ddr3_axi_tester.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_axi_tester_pkg.sv
// Shared types and constants for the DDR3 AXI traffic generator/checker.
// The LFSR step function lives here so the generator and sequencer agree on it.
package ddr3_axi_tester_pkg;

  localparam int BEAT_WORDS = 8;
  localparam int LFSR_W     = 32;
  // Fibonacci taps 32,22,2,1 expressed as bit positions 31,21,1,0
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_INIT,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    MODE_INCR     = 2'd0,
    MODE_PRBS     = 2'd1,
    MODE_WALK1    = 2'd2,
    MODE_INV_INCR = 2'd3
  } mode_e;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/ddr3_pattern_gen.sv
// Beat pattern generator: one 8-word beat from the pattern mode, the beat's
// DQ-word address and the current LFSR state. Used for both write data and read-back.
module ddr3_pattern_gen
  import ddr3_axi_tester_pkg::*;
#(
  parameter int CTRL_ADDR_WIDTH = 28,
  parameter int MEM_DQ_WIDTH    = 32
) (
  input  mode_e                                mode_i,
  input  logic [CTRL_ADDR_WIDTH-1:0]           addr_i,
  input  logic [LFSR_W-1:0]                    lfsr_i,
  output logic [BEAT_WORDS*MEM_DQ_WIDTH-1:0]   data_o
);

  logic [MEM_DQ_WIDTH-1:0] prbs_word;

  // LFSR replicated (or truncated) across the DQ word width
  for (genvar gi = 0; gi < MEM_DQ_WIDTH; gi++) begin : g_prbs
    assign prbs_word[gi] = lfsr_i[gi % LFSR_W];
  end

  for (genvar gi = 0; gi < BEAT_WORDS; gi++) begin : g_word
    logic [CTRL_ADDR_WIDTH-1:0] word_addr;
    logic [MEM_DQ_WIDTH-1:0]    incr_word;
    logic [MEM_DQ_WIDTH-1:0]    walk_word;
    logic [MEM_DQ_WIDTH-1:0]    prbs_rot;
    logic [MEM_DQ_WIDTH-1:0]    pat_word;

    assign word_addr = addr_i + CTRL_ADDR_WIDTH'(gi);
    assign incr_word = MEM_DQ_WIDTH'(word_addr);
    assign walk_word = MEM_DQ_WIDTH'(1) << (word_addr % CTRL_ADDR_WIDTH'(MEM_DQ_WIDTH));

    for (genvar gb = 0; gb < MEM_DQ_WIDTH; gb++) begin : g_rot
      assign prbs_rot[gb] = prbs_word[(gb + MEM_DQ_WIDTH - gi) % MEM_DQ_WIDTH];
    end

    always_comb begin
      pat_word = incr_word;
      case (mode_i)
        MODE_INCR:     pat_word = incr_word;
        MODE_PRBS:     pat_word = prbs_rot;
        MODE_WALK1:    pat_word = walk_word;
        MODE_INV_INCR: pat_word = ~incr_word;
        default:       pat_word = incr_word;
      endcase
    end

    assign data_o[gi*MEM_DQ_WIDTH +: MEM_DQ_WIDTH] = pat_word;
  end

endmodule

// File: rtl/ddr3_axi_tester.sv
// DDR3 AXI traffic generator/checker: writes a pattern over an address window,
// reads it back, checks every beat, and reports errors, passes and handshake stalls.
module ddr3_axi_tester
  import ddr3_axi_tester_pkg::*;
#(
  parameter int              CTRL_ADDR_WIDTH = 28,
  parameter int              MEM_DQ_WIDTH    = 32,
  parameter int              BURST_LEN       = 16,
  parameter longint unsigned START_ADDR      = 0,
  parameter longint unsigned END_ADDR        = 64'd1 << CTRL_ADDR_WIDTH,
  parameter logic [31:0]     PRBS_SEED       = 32'hACE1_2468,
  parameter int              TIMEOUT_CYC     = 4096
) (
  input  logic                                core_clk,
  input  logic                                core_clk_rst_n,
  input  logic                                ddrc_init_done,
  input  logic                                start,
  input  logic                                stop,
  input  logic [1:0]                          mode,
  input  logic                                loop_en,
  output logic [CTRL_ADDR_WIDTH-1:0]          o_m_axi_awaddr,
  output logic [3:0]                          o_m_axi_awlen,
  output logic                                o_m_axi_awvalid,
  input  logic                                i_m_axi_awready,
  output logic [BEAT_WORDS*MEM_DQ_WIDTH-1:0]  o_m_axi_wdata,
  input  logic                                i_m_axi_wready,
  input  logic                                i_m_axi_wusero_last,
  output logic [CTRL_ADDR_WIDTH-1:0]          o_m_axi_araddr,
  output logic [3:0]                          o_m_axi_arlen,
  output logic                                o_m_axi_arvalid,
  input  logic                                i_m_axi_arready,
  input  logic [BEAT_WORDS*MEM_DQ_WIDTH-1:0]  i_m_axi_rdata,
  input  logic                                i_m_axi_rvalid,
  input  logic                                i_m_axi_rlast,
  output logic                                busy,
  output logic                                done,
  output logic                                pass,
  output logic                                timeout,
  output logic [15:0]                         err_cnt,
  output logic [CTRL_ADDR_WIDTH-1:0]          first_err_addr,
  output logic [15:0]                         pass_cnt
);

  localparam int                 AW1       = CTRL_ADDR_WIDTH + 1;
  localparam int                 DW        = BEAT_WORDS * MEM_DQ_WIDTH;
  localparam int                 WDW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [AW1-1:0]     START_A   = AW1'(START_ADDR);
  localparam logic [AW1-1:0]     END_A     = AW1'(END_ADDR);
  localparam logic [AW1-1:0]     STEP_A    = AW1'(BEAT_WORDS * BURST_LEN);
  localparam logic [3:0]         LAST_BEAT = 4'(BURST_LEN - 1);

  state_e                       state_q, state_d;
  logic [AW1-1:0]               addr_q, addr_d;
  logic [3:0]                   beat_q, beat_d;
  logic [LFSR_W-1:0]            lfsr_q, lfsr_d;
  mode_e                        mode_q, mode_d;
  logic                         loop_q, loop_d;
  logic [WDW-1:0]               wdog_q, wdog_d;
  logic [15:0]                  err_cnt_q, err_cnt_d;
  logic [CTRL_ADDR_WIDTH-1:0]   first_err_q, first_err_d;
  logic [15:0]                  pass_cnt_q, pass_cnt_d;
  logic                         pass_q, pass_d;
  logic                         timeout_q, timeout_d;
  logic                         done_q, done_d;
  logic                         start_q;

  logic                         start_rise;
  logic                         active;
  logic                         progress;
  logic                         expire;
  logic                         finish;
  logic                         last_beat;
  logic                         wrap;
  logic [AW1-1:0]               addr_step;
  logic [CTRL_ADDR_WIDTH-1:0]   beat_addr;
  logic [DW-1:0]                pat_data;
  logic                         rd_beat_err;
  logic                         rd_burst_end;
  logic                         unused_inputs;

  assign unused_inputs = i_m_axi_wusero_last;

  assign start_rise   = start & ~start_q;
  assign active       = (state_q == ST_WR_ADDR) || (state_q == ST_WR_DATA) ||
                        (state_q == ST_RD_ADDR) || (state_q == ST_RD_DATA);
  assign progress     = ((state_q == ST_WR_ADDR) && i_m_axi_awready) ||
                        ((state_q == ST_WR_DATA) && i_m_axi_wready)  ||
                        ((state_q == ST_RD_ADDR) && i_m_axi_arready) ||
                        ((state_q == ST_RD_DATA) && i_m_axi_rvalid);
  assign expire       = active && !progress && (wdog_q == WDW'(TIMEOUT_CYC - 1));
  assign last_beat    = (beat_q == LAST_BEAT);
  assign addr_step    = addr_q + STEP_A;
  assign wrap         = (addr_step >= END_A);
  assign beat_addr    = addr_q[CTRL_ADDR_WIDTH-1:0] + CTRL_ADDR_WIDTH'({beat_q, 3'b000});
  // An rlast on the wrong beat, or a missing one on the final beat, is a beat error
  assign rd_beat_err  = (i_m_axi_rdata != pat_data) || (i_m_axi_rlast != last_beat);
  assign rd_burst_end = i_m_axi_rlast || last_beat;

  ddr3_pattern_gen #(
    .CTRL_ADDR_WIDTH (CTRL_ADDR_WIDTH),
    .MEM_DQ_WIDTH    (MEM_DQ_WIDTH)
  ) u_pattern_gen (
    .mode_i (mode_q),
    .addr_i (beat_addr),
    .lfsr_i (lfsr_q),
    .data_o (pat_data)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    beat_d      = beat_q;
    lfsr_d      = lfsr_q;
    mode_d      = mode_q;
    loop_d      = loop_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    pass_cnt_d  = pass_cnt_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    done_d      = 1'b0;
    finish      = 1'b0;
    wdog_d      = (active && !progress) ? wdog_q + 1'b1 : '0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_rise) begin
          state_d     = ST_WAIT_INIT;
          mode_d      = mode_e'(mode);
          loop_d      = loop_en;
          err_cnt_d   = '0;
          pass_cnt_d  = '0;
          first_err_d = '0;
          pass_d      = 1'b0;
          timeout_d   = 1'b0;
        end
      end
      ST_WAIT_INIT: begin
        if (ddrc_init_done) begin
          state_d = ST_WR_ADDR;
          addr_d  = START_A;
          beat_d  = '0;
          lfsr_d  = PRBS_SEED;
        end
      end
      ST_WR_ADDR: begin
        if (i_m_axi_awready) begin
          state_d = ST_WR_DATA;
          beat_d  = '0;
        end
      end
      ST_WR_DATA: begin
        if (i_m_axi_wready) begin
          beat_d = beat_q + 4'd1;
          lfsr_d = lfsr_step(lfsr_q);
          if (last_beat) begin
            beat_d = '0;
            if (wrap) begin
              state_d = ST_RD_ADDR;
              addr_d  = START_A;
              lfsr_d  = PRBS_SEED;
            end else begin
              state_d = ST_WR_ADDR;
              addr_d  = addr_step;
            end
          end
        end
      end
      ST_RD_ADDR: begin
        if (i_m_axi_arready) begin
          state_d = ST_RD_DATA;
          beat_d  = '0;
        end
      end
      ST_RD_DATA: begin
        if (i_m_axi_rvalid) begin
          beat_d = beat_q + 4'd1;
          lfsr_d = lfsr_step(lfsr_q);
          if (rd_beat_err) begin
            if (err_cnt_q == '0) first_err_d = beat_addr;
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
          end
          if (rd_burst_end) begin
            beat_d = '0;
            if (wrap) begin
              pass_cnt_d = pass_cnt_q + 16'd1;
              if (loop_q && !stop) begin
                state_d = ST_WR_ADDR;
                addr_d  = START_A;
                lfsr_d  = PRBS_SEED;
              end else begin
                finish = 1'b1;
              end
            end else begin
              state_d = ST_RD_ADDR;
              addr_d  = addr_step;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (expire) begin
      timeout_d = 1'b1;
      finish    = 1'b1;
    end

    if (finish) begin
      state_d = ST_DONE;
      done_d  = 1'b1;
      pass_d  = (err_cnt_d == '0) && !timeout_d;
    end
  end

  always_ff @(posedge core_clk or negedge core_clk_rst_n) begin
    if (!core_clk_rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      beat_q      <= '0;
      lfsr_q      <= PRBS_SEED;
      mode_q      <= MODE_INCR;
      loop_q      <= 1'b0;
      wdog_q      <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      pass_cnt_q  <= '0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      done_q      <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      beat_q      <= beat_d;
      lfsr_q      <= lfsr_d;
      mode_q      <= mode_d;
      loop_q      <= loop_d;
      wdog_q      <= wdog_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      pass_cnt_q  <= pass_cnt_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      done_q      <= done_d;
      start_q     <= start;
    end
  end

  // Valids decode straight from the state register so a reset drops them at once
  assign o_m_axi_awvalid = (state_q == ST_WR_ADDR);
  assign o_m_axi_arvalid = (state_q == ST_RD_ADDR);
  assign o_m_axi_awaddr  = addr_q[CTRL_ADDR_WIDTH-1:0];
  assign o_m_axi_araddr  = addr_q[CTRL_ADDR_WIDTH-1:0];
  assign o_m_axi_awlen   = LAST_BEAT;
  assign o_m_axi_arlen   = LAST_BEAT;
  assign o_m_axi_wdata   = (state_q == ST_WR_DATA) ? pat_data : '0;

  assign busy           = active || (state_q == ST_WAIT_INIT);
  assign done           = done_q;
  assign pass           = pass_q;
  assign timeout        = timeout_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_err_q;
  assign pass_cnt       = pass_cnt_q;

endmodule

// File: tb/tb_ddr3_axi_tester.sv
// Directed bench for ddr3_axi_tester: a small AXI memory model with optional
// stalls, bit-flip and early-rlast injection, and hand-computed expectations.
module tb_ddr3_axi_tester;

  localparam int AW = 28;
  localparam int DQ = 32;
  localparam int DW = 8 * DQ;
  localparam int BL = 4;
  localparam logic [AW-1:0] NO_ADDR = 28'hFFF_FFFF;

  logic          clk;
  logic          rst_n;
  logic          init_done;
  logic          start;
  logic          stop;
  logic [1:0]    mode;
  logic          loop_en;
  logic [AW-1:0] awaddr;
  logic [3:0]    awlen;
  logic          awvalid;
  logic          awready;
  logic [DW-1:0] wdata;
  logic          wready;
  logic          wusero_last;
  logic [AW-1:0] araddr;
  logic [3:0]    arlen;
  logic          arvalid;
  logic          arready;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          rlast;
  logic          busy;
  logic          done;
  logic          pass;
  logic          timeout;
  logic [15:0]   err_cnt;
  logic [AW-1:0] first_err_addr;
  logic [15:0]   pass_cnt;

  ddr3_axi_tester #(
    .CTRL_ADDR_WIDTH (AW),
    .MEM_DQ_WIDTH    (DQ),
    .BURST_LEN       (BL),
    .START_ADDR      (64'h0),
    .END_ADDR        (64'h400),
    .PRBS_SEED       (32'hACE1_2468),
    .TIMEOUT_CYC     (4096)
  ) dut (
    .core_clk            (clk),
    .core_clk_rst_n      (rst_n),
    .ddrc_init_done      (init_done),
    .start               (start),
    .stop                (stop),
    .mode                (mode),
    .loop_en             (loop_en),
    .o_m_axi_awaddr      (awaddr),
    .o_m_axi_awlen       (awlen),
    .o_m_axi_awvalid     (awvalid),
    .i_m_axi_awready     (awready),
    .o_m_axi_wdata       (wdata),
    .i_m_axi_wready      (wready),
    .i_m_axi_wusero_last (wusero_last),
    .o_m_axi_araddr      (araddr),
    .o_m_axi_arlen       (arlen),
    .o_m_axi_arvalid     (arvalid),
    .i_m_axi_arready     (arready),
    .i_m_axi_rdata       (rdata),
    .i_m_axi_rvalid      (rvalid),
    .i_m_axi_rlast       (rlast),
    .busy                (busy),
    .done                (done),
    .pass                (pass),
    .timeout             (timeout),
    .err_cnt             (err_cnt),
    .first_err_addr      (first_err_addr),
    .pass_cnt            (pass_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bench state shared between the memory model and the main sequence
  logic [DW-1:0] mem [0:127];
  int            n_cmp = 0;
  int            n_mis = 0;
  int            aw_cnt, ar_cnt, done_cnt, wr_bad;
  int            wr_left, wr_beat, rd_left, rd_beat;
  logic [AW-1:0] wr_addr, rd_addr, ba;
  logic [AW-1:0] flip_addr  = NO_ADDR;
  logic [AW-1:0] early_addr = NO_ADDR;
  bit            stall      = 1'b0;
  bit            aw_block   = 1'b0;
  bit            chk_incr   = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit go();
    return stall ? ($urandom_range(0, 1) == 1) : 1'b1;
  endfunction

  // AXI memory model: decides this cycle's inputs at the falling edge; DUT outputs
  // depend only on its registers, so the handshakes at the next rising edge are known here.
  initial begin
    awready = 1'b0; wready = 1'b0; arready = 1'b0;
    rvalid = 1'b0; rlast = 1'b0; rdata = '0; wusero_last = 1'b0;
    wr_left = 0; rd_left = 0; wr_beat = 0; rd_beat = 0;
    wr_addr = '0; rd_addr = '0;
    aw_cnt = 0; ar_cnt = 0; done_cnt = 0; wr_bad = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        wr_left = 0; rd_left = 0;
        awready = 1'b0; wready = 1'b0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
        continue;
      end
      if (done) done_cnt++;
      if (wr_left > 0 && go()) begin
        wready = 1'b1;
        ba = wr_addr + AW'(wr_beat * 8);
        mem[ba[9:3]] = wdata;
        if (chk_incr)
          for (int k = 0; k < 8; k++)
            if (wdata[k*DQ +: DQ] !== (32'(ba) + 32'(k))) wr_bad++;
        wr_beat++;
        wr_left--;
      end else begin
        wready = 1'b0;
      end
      if (rd_left > 0 && go()) begin
        ba = rd_addr + AW'(rd_beat * 8);
        rdata = mem[ba[9:3]];
        if (ba == flip_addr) rdata[0] = ~rdata[0];
        rlast  = (rd_beat == BL - 1) || (rd_addr == early_addr && rd_beat == 2);
        rvalid = 1'b1;
        if (rlast) rd_left = 0;
        else begin
          rd_beat++;
          rd_left--;
        end
      end else begin
        rvalid = 1'b0;
        rlast  = 1'b0;
      end
      awready = !aw_block && go();
      if (awvalid && awready) begin
        aw_cnt++; wr_addr = awaddr; wr_left = BL; wr_beat = 0;
      end
      arready = go();
      if (arvalid && arready) begin
        ar_cnt++; rd_addr = araddr; rd_left = BL; rd_beat = 0;
      end
    end
  end

  task automatic start_run(input logic [1:0] m, input logic lp);
    done_cnt = 0; aw_cnt = 0; ar_cnt = 0; wr_bad = 0;
    mode = m; loop_en = lp;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, input string tag);
    int n = 0;
    while (done !== 1'b1 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, 64'(done), 64'd1);
    repeat (3) @(negedge clk);
    $display("run %s: aw=%0d ar=%0d err=%0d first=%0h pass=%0b passes=%0d tmo=%0b",
             tag, aw_cnt, ar_cnt, err_cnt, first_err_addr, pass, pass_cnt, timeout);
  endtask

  task automatic check_clean(input string tag, input int exp_passes);
    chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    chk({tag, "_pass"},     64'(pass),     64'd1);
    chk({tag, "_err_cnt"},  64'(err_cnt),  64'd0);
    chk({tag, "_passes"},   64'(pass_cnt), 64'(exp_passes));
    chk({tag, "_busy"},     64'(busy),     64'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; init_done = 1'b0; start = 1'b0; stop = 1'b0;
    mode = 2'd0; loop_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_awvalid", 64'(awvalid), 64'd0);
    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_busy",    64'(busy),    64'd0);
    chk("rst_done",    64'(done),    64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("rst_awlen",   64'(awlen),   64'd3);
    chk("rst_arlen",   64'(arlen),   64'd3);
    rst_n = 1'b1;
    @(negedge clk);

    // INCR, clean memory, calibration arrives late
    chk_incr = 1'b1;
    start_run(2'd0, 1'b0);
    repeat (10) @(negedge clk);
    chk("init_wait_busy",    64'(busy),    64'd1);
    chk("init_wait_awvalid", 64'(awvalid), 64'd0);
    init_done = 1'b1;
    wait_done(2000, "incr");
    check_clean("incr", 1);
    chk("incr_aw_hs",   64'(aw_cnt), 64'd32);
    chk("incr_ar_hs",   64'(ar_cnt), 64'd32);
    chk("incr_wr_bad",  64'(wr_bad), 64'd0);
    chk("incr_timeout", 64'(timeout), 64'd0);
    chk("incr_w100_0",  64'(mem[7'h20][31:0]),    64'h100);
    chk("incr_w100_7",  64'(mem[7'h20][255:224]), 64'h107);
    chk_incr = 1'b0;

    // Single flipped bit at beat address 'h100
    flip_addr = 28'h100;
    start_run(2'd0, 1'b0);
    wait_done(2000, "flip");
    chk("flip_err_cnt",   64'(err_cnt),        64'd1);
    chk("flip_first_err", 64'(first_err_addr), 64'h100);
    chk("flip_pass",      64'(pass),           64'd0);
    chk("flip_done_cnt",  64'(done_cnt),       64'd1);
    flip_addr = NO_ADDR;

    // Early rlast on beat 2 of the burst at 'h40 (beat address 'h50)
    early_addr = 28'h40;
    start_run(2'd0, 1'b0);
    wait_done(2000, "early_rlast");
    chk("early_err_cnt",   64'(err_cnt),        64'd1);
    chk("early_first_err", 64'(first_err_addr), 64'h50);
    chk("early_ar_hs",     64'(ar_cnt),         64'd32);
    chk("early_pass",      64'(pass),           64'd0);
    early_addr = NO_ADDR;

    // WALK1: beat 'h28 -> 40 mod 32 = 8, so words are 1<<8 .. 1<<15
    start_run(2'd2, 1'b0);
    wait_done(2000, "walk1");
    check_clean("walk1", 1);
    chk("walk1_w28_0", 64'(mem[7'h05][31:0]),    64'h100);
    chk("walk1_w28_7", 64'(mem[7'h05][255:224]), 64'h8000);

    // INV_INCR
    start_run(2'd3, 1'b0);
    wait_done(2000, "inv_incr");
    check_clean("inv_incr", 1);
    chk("inv_w28_0", 64'(mem[7'h05][31:0]), 64'hFFFF_FFD7);

    // PRBS loop with random stalls; stop raised during the third pass
    stall = 1'b1;
    start_run(2'd1, 1'b1);
    n = 0;
    while (pass_cnt != 16'd2 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("prbs_reach_pass3", 64'(pass_cnt), 64'd2);
    repeat (50) @(negedge clk);
    stop = 1'b1;
    wait_done(20000, "prbs_loop");
    stop = 1'b0;
    stall = 1'b0;
    check_clean("prbs", 3);
    chk("prbs_b0_w0", 64'(mem[7'h00][31:0]),  64'hACE1_2468);
    chk("prbs_b0_w1", 64'(mem[7'h00][63:32]), 64'h59C2_48D1);
    chk("prbs_b1_w0", 64'(mem[7'h01][31:0]),  64'h59C2_48D0);

    // Write-address handshake never completes: watchdog
    aw_block = 1'b1;
    start_run(2'd0, 1'b0);
    repeat (4000) @(negedge clk);
    chk("tmo_awvalid_before", 64'(awvalid), 64'd1);
    chk("tmo_flag_before",    64'(timeout), 64'd0);
    wait_done(500, "timeout");
    chk("tmo_flag",     64'(timeout),  64'd1);
    chk("tmo_pass",     64'(pass),     64'd0);
    chk("tmo_awvalid",  64'(awvalid),  64'd0);
    chk("tmo_done_cnt", 64'(done_cnt), 64'd1);
    chk("tmo_aw_hs",    64'(aw_cnt),   64'd0);
    aw_block = 1'b0;

    // Asynchronous reset in the middle of a write burst of the second pass
    flip_addr = 28'h100;
    start_run(2'd0, 1'b1);
    n = 0;
    while (pass_cnt != 16'd1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_rst_err_before", 64'(err_cnt), 64'd1);
    n = 0;
    while (wr_left == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_awvalid",  64'(awvalid),  64'd0);
    chk("mid_rst_arvalid",  64'(arvalid),  64'd0);
    chk("mid_rst_busy",     64'(busy),     64'd0);
    chk("mid_rst_err_cnt",  64'(err_cnt),  64'd0);
    chk("mid_rst_pass_cnt", 64'(pass_cnt), 64'd0);
    flip_addr = NO_ADDR;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
